// File: rtl/vx_alu_req_unit_if.sv
// rtl/vx_alu_req_unit_if.sv - ALU request and commit handshake bundle
interface vx_alu_req_unit_if #(
  parameter int NUM_THREADS   = 4,
  parameter int UUID_BITS     = 44,
  parameter int NW_BITS       = 2,
  parameter int NT_BITS       = 2,
  parameter int NR_BITS       = 5,
  parameter int INST_ALU_BITS = 4,
  parameter int INST_MOD_BITS = 3
);
  // Request side (dispatch -> ALU unit)
  logic                          alu_req_valid;
  logic [UUID_BITS-1:0]          alu_req_uuid;
  logic [NW_BITS-1:0]            alu_req_wid;
  logic [NUM_THREADS-1:0]        alu_req_tmask;
  logic [31:0]                   alu_req_PC;
  logic [31:0]                   alu_req_next_PC;
  logic [INST_ALU_BITS-1:0]      alu_req_op_type;
  logic [INST_MOD_BITS-1:0]      alu_req_op_mod;
  logic                          alu_req_use_PC;
  logic                          alu_req_use_imm;
  logic [31:0]                   alu_req_imm;
  logic [NT_BITS-1:0]            alu_req_tid;
  logic [NUM_THREADS-1:0][31:0]  alu_req_rs1_data;
  logic [NUM_THREADS-1:0][31:0]  alu_req_rs2_data;
  logic [NR_BITS-1:0]            alu_req_rd;
  logic                          alu_req_wb;
  logic                          alu_req_ready;

  // Commit side (ALU unit -> writeback)
  logic                          commit_valid;
  logic [UUID_BITS-1:0]          commit_uuid;
  logic [NW_BITS-1:0]            commit_wid;
  logic [NUM_THREADS-1:0]        commit_tmask;
  logic [31:0]                   commit_PC;
  logic [NUM_THREADS-1:0][31:0]  commit_data;
  logic [NR_BITS-1:0]            commit_rd;
  logic                          commit_wb;
  logic                          commit_ready;

  modport master (
    output alu_req_valid, alu_req_uuid, alu_req_wid, alu_req_tmask, alu_req_PC,
           alu_req_next_PC, alu_req_op_type, alu_req_op_mod, alu_req_use_PC,
           alu_req_use_imm, alu_req_imm, alu_req_tid, alu_req_rs1_data,
           alu_req_rs2_data, alu_req_rd, alu_req_wb, commit_ready,
    input  alu_req_ready, commit_valid, commit_uuid, commit_wid, commit_tmask,
           commit_PC, commit_data, commit_rd, commit_wb
  );

  modport slave (
    input  alu_req_valid, alu_req_uuid, alu_req_wid, alu_req_tmask, alu_req_PC,
           alu_req_next_PC, alu_req_op_type, alu_req_op_mod, alu_req_use_PC,
           alu_req_use_imm, alu_req_imm, alu_req_tid, alu_req_rs1_data,
           alu_req_rs2_data, alu_req_rd, alu_req_wb, commit_ready,
    output alu_req_ready, commit_valid, commit_uuid, commit_wid, commit_tmask,
           commit_PC, commit_data, commit_rd, commit_wb
  );
endinterface

// File: rtl/vx_alu_req_unit.sv
// rtl/vx_alu_req_unit.sv - buffered per-thread integer ALU with registered commit
module vx_alu_req_unit #(
  parameter int BUF_DEPTH     = 2,
  parameter int PERF_EN       = 1,
  parameter int NUM_THREADS   = 4,
  parameter int UUID_BITS     = 44,
  parameter int NW_BITS       = 2,
  parameter int NR_BITS       = 5,
  parameter int INST_ALU_BITS = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  vx_alu_req_unit_if.slave   alu_if,
  output logic [31:0]        perf_stalls
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PW:0] CNT_FULL = (PW+1)'(BUF_DEPTH);

  localparam logic [INST_ALU_BITS-1:0] ALU_ADD  = INST_ALU_BITS'(0);
  localparam logic [INST_ALU_BITS-1:0] ALU_SUB  = INST_ALU_BITS'(1);
  localparam logic [INST_ALU_BITS-1:0] ALU_SLL  = INST_ALU_BITS'(2);
  localparam logic [INST_ALU_BITS-1:0] ALU_SLT  = INST_ALU_BITS'(3);
  localparam logic [INST_ALU_BITS-1:0] ALU_SLTU = INST_ALU_BITS'(4);
  localparam logic [INST_ALU_BITS-1:0] ALU_XOR  = INST_ALU_BITS'(5);
  localparam logic [INST_ALU_BITS-1:0] ALU_SRL  = INST_ALU_BITS'(6);
  localparam logic [INST_ALU_BITS-1:0] ALU_SRA  = INST_ALU_BITS'(7);
  localparam logic [INST_ALU_BITS-1:0] ALU_OR   = INST_ALU_BITS'(8);
  localparam logic [INST_ALU_BITS-1:0] ALU_AND  = INST_ALU_BITS'(9);
  localparam logic [INST_ALU_BITS-1:0] ALU_LUI  = INST_ALU_BITS'(10);

  typedef struct packed {
    logic [UUID_BITS-1:0]         uuid;
    logic [NW_BITS-1:0]           wid;
    logic [NUM_THREADS-1:0]       tmask;
    logic [31:0]                  pc;
    logic [INST_ALU_BITS-1:0]     op;
    logic                         use_pc;
    logic                         use_imm;
    logic [31:0]                  imm;
    logic [NUM_THREADS-1:0][31:0] rs1;
    logic [NUM_THREADS-1:0][31:0] rs2;
    logic [NR_BITS-1:0]           rd;
    logic                         wb;
  } req_t;

  req_t                          buf_q [BUF_DEPTH];
  req_t                          in_req;
  req_t                          head;
  logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [PW:0]                   count_q, count_d;
  logic                          ready_q;
  logic                          push, pop;
  logic [31:0]                   op_a, op_b;
  logic [NUM_THREADS-1:0][31:0]  exec_data;

  logic                          commit_valid_q, commit_valid_d;
  logic [UUID_BITS-1:0]          commit_uuid_q;
  logic [NW_BITS-1:0]            commit_wid_q;
  logic [NUM_THREADS-1:0]        commit_tmask_q;
  logic [31:0]                   commit_pc_q;
  logic [NUM_THREADS-1:0][31:0]  commit_data_q;
  logic [NR_BITS-1:0]            commit_rd_q;
  logic                          commit_wb_q;

  // Capture the incoming request fields that the execute stage needs.
  always_comb begin
    in_req         = '0;
    in_req.uuid    = alu_if.alu_req_uuid;
    in_req.wid     = alu_if.alu_req_wid;
    in_req.tmask   = alu_if.alu_req_tmask;
    in_req.pc      = alu_if.alu_req_PC;
    in_req.op      = alu_if.alu_req_op_type;
    in_req.use_pc  = alu_if.alu_req_use_PC;
    in_req.use_imm = alu_if.alu_req_use_imm;
    in_req.imm     = alu_if.alu_req_imm;
    in_req.rs1     = alu_if.alu_req_rs1_data;
    in_req.rs2     = alu_if.alu_req_rs2_data;
    in_req.rd      = alu_if.alu_req_rd;
    in_req.wb      = alu_if.alu_req_wb;
  end

  // Handshake and pointer/count next-state; ready comes only from registered state.
  always_comb begin
    push     = alu_if.alu_req_valid && ready_q;
    pop      = (count_q != '0) && (!commit_valid_q || alu_if.commit_ready);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    commit_valid_d = commit_valid_q;
    if (pop) begin
      commit_valid_d = 1'b1;
    end else if (alu_if.commit_ready) begin
      commit_valid_d = 1'b0;
    end
  end

  // Buffer storage is never observed before being written, so it is not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_ptr_q] <= in_req;
    end
  end

  // Buffer control state; ready is held low while in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= (count_d != CNT_FULL);
    end
  end

  // Per-lane integer execute on the buffer head; inactive lanes compute too.
  always_comb begin
    head      = buf_q[rd_ptr_q];
    exec_data = '0;
    op_a      = '0;
    op_b      = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      op_a = head.use_pc  ? head.pc  : head.rs1[i];
      op_b = head.use_imm ? head.imm : head.rs2[i];
      case (head.op)
        ALU_ADD:  exec_data[i] = op_a + op_b;
        ALU_SUB:  exec_data[i] = op_a - op_b;
        ALU_SLL:  exec_data[i] = op_a << op_b[4:0];
        ALU_SLT:  exec_data[i] = {31'd0, ($signed(op_a) < $signed(op_b))};
        ALU_SLTU: exec_data[i] = {31'd0, (op_a < op_b)};
        ALU_XOR:  exec_data[i] = op_a ^ op_b;
        ALU_SRL:  exec_data[i] = op_a >> op_b[4:0];
        ALU_SRA:  exec_data[i] = $unsigned($signed(op_a) >>> op_b[4:0]);
        ALU_OR:   exec_data[i] = op_a | op_b;
        ALU_AND:  exec_data[i] = op_a & op_b;
        ALU_LUI:  exec_data[i] = op_b;
        default:  exec_data[i] = '0;
      endcase
    end
  end

  // Commit register: loads on pop, holds while downstream stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      commit_valid_q <= 1'b0;
      commit_uuid_q  <= '0;
      commit_wid_q   <= '0;
      commit_tmask_q <= '0;
      commit_pc_q    <= '0;
      commit_data_q  <= '0;
      commit_rd_q    <= '0;
      commit_wb_q    <= 1'b0;
    end else begin
      commit_valid_q <= commit_valid_d;
      if (pop) begin
        commit_uuid_q  <= head.uuid;
        commit_wid_q   <= head.wid;
        commit_tmask_q <= head.tmask;
        commit_pc_q    <= head.pc;
        commit_data_q  <= exec_data;
        commit_rd_q    <= head.rd;
        commit_wb_q    <= head.wb;
      end
    end
  end

  assign alu_if.alu_req_ready = ready_q;
  assign alu_if.commit_valid  = commit_valid_q;
  assign alu_if.commit_uuid   = commit_uuid_q;
  assign alu_if.commit_wid    = commit_wid_q;
  assign alu_if.commit_tmask  = commit_tmask_q;
  assign alu_if.commit_PC     = commit_pc_q;
  assign alu_if.commit_data   = commit_data_q;
  assign alu_if.commit_rd     = commit_rd_q;
  assign alu_if.commit_wb     = commit_wb_q;

  generate
    if (PERF_EN != 0) begin : g_perf
      logic [31:0] stall_q;
      // Saturating count of cycles where a request waits on a full buffer.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          stall_q <= '0;
        end else if (alu_if.alu_req_valid && !ready_q && (stall_q != 32'hFFFF_FFFF)) begin
          stall_q <= stall_q + 32'd1;
        end
      end
      assign perf_stalls = stall_q;
    end else begin : g_no_perf
      assign perf_stalls = '0;
    end
  endgenerate

endmodule
